mp_ram_array: RTL

//  Parametrised multi-port storage array: DEPTH words x DATA_W bits, NUM_PORTS independent

---
 rtl/mp_ram_pkg.sv | 27 ++
 rtl/mp_ram_if.sv | 32 +++
 rtl/mp_ram_word.sv | 32 +++
 rtl/mp_ram_array.sv | 116 +++++++++++
 4 files changed

// File: rtl/mp_ram_pkg.sv
// Shared constants and helpers for the multi-port RAM array.
package mp_ram_pkg;

    localparam int unsigned NUM_PORTS_DEF = 3;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned DEPTH_DEF     = 16;
    localparam int unsigned CNT_W_DEF     = 8;

    localparam int unsigned PORT_L = 0;
    localparam int unsigned PORT_R = 1;
    localparam int unsigned PORT_M = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

    // A single-word array still needs a one-bit address bus.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (clog2(depth) == 0) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/mp_ram_if.sv
// Port bundle for mp_ram_array: per-port request fields plus registered responses.
interface mp_ram_if
    import mp_ram_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) ();

    localparam int unsigned AW = addr_width(DEPTH);

    logic [NUM_PORTS-1:0]        sel;
    logic [NUM_PORTS-1:0]        wr;
    logic [NUM_PORTS*AW-1:0]     addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS*DATA_W-1:0] rdata;
    logic [NUM_PORTS-1:0]        rvalid;
    logic [NUM_PORTS-1:0]        wr_conflict;
    logic [CNT_W-1:0]            conflict_cnt;

    modport master (
        output sel, wr, addr, wdata,
        input  rdata, rvalid, wr_conflict, conflict_cnt
    );

    modport slave (
        input  sel, wr, addr, wdata,
        output rdata, rvalid, wr_conflict, conflict_cnt
    );

endinterface

// File: rtl/mp_ram_word.sv
// One storage word with per-port write enables; lowest enabled port index wins.
module mp_ram_word
    import mp_ram_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [DATA_W-1:0]           q
);

    logic [DATA_W-1:0] word_q, word_d;

    // Walk from highest to lowest so the lowest enabled port overrides.
    always_comb begin
        word_d = word_q;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (we[p]) word_d = wdata[p*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) word_q <= '0;
        else     word_q <= word_d;
    end

    assign q = word_q;

endmodule

// File: rtl/mp_ram_array.sv
// Multi-port flop RAM with write priority, collision counting and registered reads.
// Define MP_RAM_WRITE_THROUGH_EN to bypass same-cycle write data to readers (else read-first).
module mp_ram_array
    import mp_ram_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    mp_ram_if.slave    bus
);

    localparam int unsigned AW = addr_width(DEPTH);
    localparam int unsigned SW = CNT_W + clog2(NUM_PORTS) + 1;

    logic [AW-1:0]     addr_p  [NUM_PORTS];
    logic [DATA_W-1:0] wdata_p [NUM_PORTS];
    logic [DATA_W-1:0] mem     [DEPTH];

    logic [NUM_PORTS-1:0] in_range;
    logic [NUM_PORTS-1:0] wr_req;
    logic [NUM_PORTS-1:0] rd_req;
    logic [NUM_PORTS-1:0] lose;

    logic [NUM_PORTS*DATA_W-1:0] rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]        rvalid_q, wr_conflict_q;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [SW-1:0]               cnt_sum;
    logic [DATA_W-1:0]           rd_val;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            addr_p[p]   = bus.addr[p*AW +: AW];
            wdata_p[p]  = bus.wdata[p*DATA_W +: DATA_W];
            in_range[p] = 32'(addr_p[p]) < DEPTH;
            wr_req[p]   = bus.sel[p] & bus.wr[p] & in_range[p];
            rd_req[p]   = bus.sel[p] & ~bus.wr[p];
        end
    end

    // A write loses when any lower-index port writes the same in-range word.
    always_comb begin
        lose = '0;
        for (int p = 1; p < NUM_PORTS; p++) begin
            for (int q = 0; q < p; q++) begin
                if (wr_req[p] && wr_req[q] && addr_p[p] == addr_p[q]) lose[p] = 1'b1;
            end
        end
    end

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        logic [NUM_PORTS-1:0] we;
        always_comb begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                we[p] = wr_req[p] && (32'(addr_p[p]) == w);
            end
        end
        mp_ram_word #(
            .NUM_PORTS (NUM_PORTS),
            .DATA_W    (DATA_W)
        ) u_word (
            .clk   (clk),
            .rst   (rst),
            .we    (we),
            .wdata (bus.wdata),
            .q     (mem[w])
        );
    end

    always_comb begin
        rdata_d = rdata_q;
        rd_val  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_val = '0;
            if (in_range[p]) rd_val = mem[addr_p[p]];
`ifdef MP_RAM_WRITE_THROUGH_EN
            for (int q = NUM_PORTS - 1; q >= 0; q--) begin
                if (wr_req[q] && addr_p[q] == addr_p[p]) rd_val = wdata_p[q];
            end
`endif
            if (rd_req[p]) rdata_d[p*DATA_W +: DATA_W] = rd_val;
        end
    end

    always_comb begin
        cnt_sum = SW'(cnt_q);
        for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_sum = cnt_sum + SW'(lose[p]);
        end
        if (cnt_sum > SW'({CNT_W{1'b1}})) cnt_d = '1;
        else                              cnt_d = cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q       <= '0;
            rvalid_q      <= '0;
            wr_conflict_q <= '0;
            cnt_q         <= '0;
        end else begin
            rdata_q       <= rdata_d;
            rvalid_q      <= rd_req;
            wr_conflict_q <= lose;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.rdata        = rdata_q;
    assign bus.rvalid       = rvalid_q;
    assign bus.wr_conflict  = wr_conflict_q;
    assign bus.conflict_cnt = cnt_q;

endmodule
